// File: rtl/alu_pkg.sv
// Shared encodings for the EX-stage ALU: ALU_Mid/Func field values, the internal
// operation set produced by decode, and the mult/div sequencer states.
package alu_pkg;

    localparam logic [2:0] MID_ADD   = 3'b000;
    localparam logic [2:0] MID_SUB   = 3'b001;
    localparam logic [2:0] MID_AND   = 3'b010;
    localparam logic [2:0] MID_OR    = 3'b011;
    localparam logic [2:0] MID_XOR   = 3'b100;
    localparam logic [2:0] MID_SLT   = 3'b101;
    localparam logic [2:0] MID_LUI   = 3'b110;
    localparam logic [2:0] MID_RTYPE = 3'b111;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_XNOR  = 6'b001100;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLTU  = 6'b101011;
    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    typedef enum logic [4:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_XNOR,
        OP_SLT, OP_SLTU, OP_SLL, OP_SRL, OP_SRA, OP_LUI,
        OP_MFHI, OP_MFLO, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_ILL
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIXUP
    } md_state_t;

    function automatic logic is_muldiv(input alu_op_t op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative multiplier/divider: one bit per cycle on operand magnitudes, followed by
// a single FIXUP cycle that applies the sign correction and presents hi/lo with done.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_t state, state_next;

    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic [SHW-1:0]     cnt;
    logic               res_neg;
    logic               rem_neg;
    logic               div_op;

    logic               div_zero;
    logic               neg_a;
    logic               neg_b;
    logic [WIDTH-1:0]   load_a;
    logic [WIDTH-1:0]   load_b;
    logic               last_bit;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_next;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_raw;
    logic [WIDTH-1:0]   rem_raw;

    // Divide-by-zero runs on the raw dividend with no sign fix, so the
    // restoring loop naturally yields an all-ones quotient and remainder == a.
    always_comb begin
        div_zero = is_div && (b == '0);
        neg_a    = signed_op && a[WIDTH-1] && !div_zero;
        neg_b    = signed_op && b[WIDTH-1] && !div_zero;
        load_a   = neg_a ? (~a + 1'b1) : a;
        load_b   = neg_b ? (~b + 1'b1) : b;
        last_bit = (cnt == SHW'(WIDTH - 1));
    end

    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_next  = {mul_sum, acc[WIDTH-1:1]};
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_next = is_div ? ST_DIV : ST_MUL;
                end
            end
            ST_MUL, ST_DIV: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (last_bit) begin
                    state_next = ST_FIXUP;
                end
            end
            ST_FIXUP: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != ST_IDLE);
        done = (state == ST_FIXUP) && !abort;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            opnd    <= '0;
            cnt     <= '0;
            res_neg <= 1'b0;
            rem_neg <= 1'b0;
            div_op  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        acc     <= {{WIDTH{1'b0}}, load_a};
                        opnd    <= load_b;
                        cnt     <= '0;
                        res_neg <= neg_a ^ neg_b;
                        rem_neg <= neg_a;
                        div_op  <= is_div;
                    end
                end
                ST_MUL: begin
                    acc <= mul_next;
                    cnt <= cnt + SHW'(1);
                end
                ST_DIV: begin
                    acc <= div_next;
                    cnt <= cnt + SHW'(1);
                end
                default: ;
            endcase
        end
    end

    // Sign correction; only sampled by the parent while done is high.
    always_comb begin
        prod_fix = res_neg ? (~acc + 1'b1) : acc;
        quo_raw  = acc[WIDTH-1:0];
        rem_raw  = acc[2*WIDTH-1:WIDTH];
        if (div_op) begin
            hi = rem_neg ? (~rem_raw + 1'b1) : rem_raw;
            lo = res_neg ? (~quo_raw + 1'b1) : quo_raw;
        end else begin
            hi = prod_fix[2*WIDTH-1:WIDTH];
            lo = prod_fix[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage ALU: decodes ALU_Mid/Func, executes single-cycle ops with a registered
// result, and sequences mult/div into HI/LO while stalling the pipe via in_ready.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_mid,
    input  logic [5:0]       func,
    input  logic [SHW-1:0]   shamt,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic             illegal,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    alu_op_t          op;
    logic             chk_ovf;
    logic             accept;
    logic             op_md;
    logic             md_start;
    logic             md_signed;
    logic             md_is_div;
    logic             md_busy;
    logic             md_done;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] md_lo;

    logic [WIDTH-1:0] add_sum;
    logic [WIDTH-1:0] sub_diff;
    logic             add_ovf;
    logic             sub_ovf;
    logic             slt_s;
    logic             slt_u;
    logic [WIDTH-1:0] res_d;
    logic             ovf_d;
    logic             ill_d;

    // Only the R-type add/sub encodings check for overflow; I-type and the
    // unsigned variants share the same datapath with the check disabled.
    always_comb begin
        op      = OP_ILL;
        chk_ovf = 1'b0;
        case (alu_mid)
            MID_ADD: op = OP_ADD;
            MID_SUB: op = OP_SUB;
            MID_AND: op = OP_AND;
            MID_OR:  op = OP_OR;
            MID_XOR: op = OP_XOR;
            MID_SLT: op = OP_SLT;
            MID_LUI: op = OP_LUI;
            MID_RTYPE: begin
                case (func)
                    FN_ADD:   begin op = OP_ADD; chk_ovf = 1'b1; end
                    FN_ADDU:  op = OP_ADD;
                    FN_SUB:   begin op = OP_SUB; chk_ovf = 1'b1; end
                    FN_SUBU:  op = OP_SUB;
                    FN_AND:   op = OP_AND;
                    FN_OR:    op = OP_OR;
                    FN_XOR:   op = OP_XOR;
                    FN_NOR:   op = OP_NOR;
                    FN_XNOR:  op = OP_XNOR;
                    FN_SLT:   op = OP_SLT;
                    FN_SLTU:  op = OP_SLTU;
                    FN_SLL:   op = OP_SLL;
                    FN_SRL:   op = OP_SRL;
                    FN_SRA:   op = OP_SRA;
                    FN_MFHI:  op = OP_MFHI;
                    FN_MFLO:  op = OP_MFLO;
                    FN_MULT:  op = OP_MULT;
                    FN_MULTU: op = OP_MULTU;
                    FN_DIV:   op = OP_DIV;
                    FN_DIVU:  op = OP_DIVU;
                    default:  op = OP_ILL;
                endcase
            end
            default: op = OP_ILL;
        endcase
    end

    always_comb begin
        in_ready  = !md_busy;
        accept    = in_valid && in_ready && !flush;
        op_md     = is_muldiv(op);
        md_start  = accept && op_md;
        md_signed = (op == OP_MULT) || (op == OP_DIV);
        md_is_div = (op == OP_DIV) || (op == OP_DIVU);
    end

    always_comb begin
        add_sum  = op_a + op_b;
        sub_diff = op_a - op_b;
        add_ovf  = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (add_sum[WIDTH-1] != op_a[WIDTH-1]);
        sub_ovf  = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (sub_diff[WIDTH-1] != op_a[WIDTH-1]);
        slt_s    = $signed(op_a) < $signed(op_b);
        slt_u    = op_a < op_b;
    end

    always_comb begin
        res_d = '0;
        ovf_d = 1'b0;
        ill_d = 1'b0;
        case (op)
            OP_ADD:  begin res_d = add_sum;  ovf_d = chk_ovf && add_ovf; end
            OP_SUB:  begin res_d = sub_diff; ovf_d = chk_ovf && sub_ovf; end
            OP_AND:  res_d = op_a & op_b;
            OP_OR:   res_d = op_a | op_b;
            OP_XOR:  res_d = op_a ^ op_b;
            OP_NOR:  res_d = ~(op_a | op_b);
            OP_XNOR: res_d = ~(op_a ^ op_b);
            OP_SLT:  res_d = {{(WIDTH-1){1'b0}}, slt_s};
            OP_SLTU: res_d = {{(WIDTH-1){1'b0}}, slt_u};
            OP_SLL:  res_d = op_b << shamt;
            OP_SRL:  res_d = op_b >> shamt;
            OP_SRA:  res_d = $unsigned($signed(op_b) >>> shamt);
            OP_LUI:  res_d = op_b << (WIDTH / 2);
            OP_MFHI: res_d = hi;
            OP_MFLO: res_d = lo;
            OP_ILL:  ill_d = 1'b1;
            default: ;
        endcase
    end

    muldiv_iter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_muldiv (
        .clk       (clk),
        .rst       (rst),
        .start     (md_start),
        .signed_op (md_signed),
        .is_div    (md_is_div),
        .a         (op_a),
        .b         (op_b),
        .abort     (flush),
        .busy      (md_busy),
        .done      (md_done),
        .hi        (md_hi),
        .lo        (md_lo)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            ovf       <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            out_valid <= accept && !op_md;
            if (accept && !op_md) begin
                result  <= res_d;
                ovf     <= ovf_d;
                illegal <= ill_d;
            end
        end
    end

    // HI/LO only move on a completed (non-aborted) mult/div.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (md_done) begin
            hi <= md_hi;
            lo <= md_lo;
        end
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Parametrised successor to the single-cycle ALU op decoder. Decodes the ALU_Mid/Func encoding and executes the operation with a registered result.
- Adds the following over the single-cycle decoder:
  - shift operations
  - signed/unsigned compare distinction
  - lui
  - signed add/sub overflow detection
  - iterative multi-cycle mult/div into HI/LO
- Sits in the EX stage of the pipeline. It drives `in_ready` low as a stall to the hazard unit while a mult/div is in progress.

Parameters:
- WIDTH, 32, datapath width; must be even and ≥ 8.
- SHW, $clog2(WIDTH), shift-amount width.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- flush  in  1  cancel input, pending output and any mult/div in progress
- in_valid  in  1  operation presented
- in_ready  out  1  unit can accept; low while mult/div is busy
- alu_mid  in  3  I-type class; 3'b111 selects R-type Func decode
- func  in  6  R-type function field
- shamt  in  SHW  shift amount for sll/srl/sra
- op_a  in  WIDTH  rs operand
- op_b  in  WIDTH  rt or immediate operand
- out_valid  out  1  result valid (one-cycle pulse per producing op)
- result  out  WIDTH  registered result
- ovf  out  1  signed overflow (add/sub only), qualified by out_valid
- illegal  out  1  undecodable op, qualified by out_valid
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset values:
  - `out_valid`, `result`, `ovf`, `illegal`, `hi`, `lo` = 0
  - state = IDLE
  - `in_ready` = 1
- Accept condition: `in_valid && in_ready && !flush` at a rising edge.
- I-type decode (alu_mid):
  - 000 add
  - 001 sub
  - 010 and
  - 011 or
  - 100 xor
  - 101 slt (signed)
  - 110 lui: result = op_b << (WIDTH/2)
  - 111 → R-type decode below
- R-type decode (func):
  - 100000 add (ovf)
  - 100001 addu
  - 100010 sub (ovf)
  - 100011 subu
  - 100100 and
  - 100101 or
  - 100110 xor
  - 100111 nor
  - 001100 xnor
  - 101010 slt signed
  - 101011 sltu unsigned
  - 000000 sll: op_b << shamt
  - 000010 srl: op_b >> shamt, logical
  - 000011 sra: op_b >> shamt, arithmetic
  - 010000 mfhi
  - 010010 mflo
  - 011000 mult
  - 011001 multu
  - 011010 div
  - 011011 divu
- Single-cycle ops:
  - Result, `ovf` and `illegal` are registered; `out_valid`=1 on the cycle after acceptance (latency 1).
  - slt/sltu produce 0 or 1, zero-extended.
  - All arithmetic is modulo 2^WIDTH.
  - `ovf`=1 only for add/sub, when the operand signs match and the result sign differs (add), or the operand signs differ and the result sign differs from op_a (sub).
  - I-type add/sub never raise `ovf`.
- Illegal func: `out_valid`=1, `result`=0, `illegal`=1. X is never driven.
- mfhi/mflo: single-cycle; return the `hi`/`lo` value at acceptance. They cannot be accepted while busy, so they always observe completed values.
- Mult/div FSM, states IDLE → MUL | DIV → FIXUP → IDLE:
  - On accept, latch operand magnitudes (signed ops) or raw values (unsigned ops), plus the result signs.
  - MUL: shift-add, one bit per cycle, WIDTH cycles, 2·WIDTH product.
  - DIV: restoring, one bit per cycle, WIDTH cycles.
  - FIXUP (1 cycle):
    - apply sign correction
    - mult: {hi,lo} = product
    - div: lo = quotient, hi = remainder
    - quotient sign = sign(a)^sign(b); remainder sign = sign(a)
  - `hi`/`lo` update at the edge leaving FIXUP.
  - `in_ready`=0 from the cycle after acceptance for exactly WIDTH+1 cycles.
  - mult/div never assert `out_valid`.
- Divide by zero: lo = all ones, hi = op_a (unsigned magnitude path, sign fix skipped).
- Signed INT_MIN / −1: lo = INT_MIN, hi = 0.
- Flush:
  - Synchronous. Clears `out_valid` next cycle and drops any input presented in the same cycle.
  - Aborts MUL/DIV/FIXUP to IDLE with `hi`/`lo` unchanged; `in_ready`=1 next cycle.
- Reset mid-operation: immediate return to the reset values above.

Decomposition:
- Package `alu_pkg`:
  - Func and ALU_Mid localparam constants
  - internal op enum (ADD, SUB, AND, OR, XOR, NOR, XNOR, SLT, SLTU, SLL, SRL, SRA, LUI, MFHI, MFLO, MULT, MULTU, DIV, DIVU, ILL)
  - FSM state enum
- Sub-module `muldiv_iter`:
  - inputs: start, signed, is_div, a, b, abort
  - outputs: busy, done, hi, lo
  - contains the counter and FIXUP stage
- The top level holds the decode, the single-cycle datapath and the HI/LO registers.

Test Plan (WIDTH=32):
- Add overflow: add 0x7FFFFFFF + 1 (func 100000) → next cycle result 0x80000000, ovf=1; same operands via addu → ovf=0.
- Compare and shift:
  - slt a=0xFFFFFFFF, b=1 → 1; sltu on the same operands → 0.
  - sra b=0x80000000, shamt=4 → 0xF8000000.
  - lui b=0x1234 → 0x12340000.
- Signed mult:
  - mult a=−3 (0xFFFFFFFD), b=7 → in_ready low for 33 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB.
  - A following mflo → result 0xFFFFFFEB.
- Divide:
  - div a=−7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - divu a=7, b=0 → lo=0xFFFFFFFF, hi=7.
- Flush/reset abort:
  - flush at cycle 10 of a multu → in_ready=1 next cycle, hi/lo hold their prior values.
  - rst asserted mid-DIV → all outputs 0 immediately.
- Illegal func 111111 → out_valid=1, result=0, illegal=1; in_valid held low → out_valid stays 0.
